// File: rtl/object_readout_ctrl_if.sv
// Object output stream between the readout scheduler and the downstream
// feature/overlay logic. The scheduler drives this bus through the master modport.
//
//   out_valid  emitted object available (master -> slave)
//   out_ready  downstream accept (slave -> master)
//   out_id     emitted object id
//   out_area   object area (m00)
//   out_x      x moment sum (m10)
//   out_y      y moment sum (m01)
interface object_readout_ctrl_if #(
    parameter int unsigned LBL_WIDTH = 8,
    parameter int unsigned LOC_SIZE  = 16
);
    logic                 out_valid;
    logic                 out_ready;
    logic [LBL_WIDTH-1:0] out_id;
    logic [LOC_SIZE-1:0]  out_area;
    logic [LOC_SIZE-1:0]  out_x;
    logic [LOC_SIZE-1:0]  out_y;

    modport master (
        output out_valid,
        output out_id,
        output out_area,
        output out_x,
        output out_y,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_id,
        input  out_area,
        input  out_x,
        input  out_y,
        output out_ready
    );
endinterface

// File: rtl/object_readout_ctrl.sv
// Post-frame object readout scheduler for the connected-components labeller.
// After a frame-done pulse it walks obj_id over labels 1..num_labels-1, waits out the
// table read latency for each, and emits root labels whose area reaches MIN_AREA on a
// valid/ready stream. busy gates the labeller while the scan runs.
//
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   frame_done  one-cycle pulse at end of frame labelling
//   num_labels  next-free-label count, valid with frame_done
//   obj_id      label id driven to the labeller readout port
//   obj_root    merge-resolved id of obj_id (RD_LAT cycles after obj_id changes)
//   obj_area/x/y  moment sums of the resolved object
//   busy        scan in progress
//   out_count   objects emitted during this scan (saturating)
//   scan_done   one-cycle pulse at end of scan
//   overrun     one-cycle pulse when frame_done arrived during a scan
//   out_bus     emitted-object stream (master side)
module object_readout_ctrl #(
    parameter int unsigned LBL_WIDTH = 8,
    parameter int unsigned LOC_SIZE  = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MIN_AREA  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_done,
    input  logic [LBL_WIDTH-1:0] num_labels,
    output logic [LBL_WIDTH-1:0] obj_id,
    input  logic [LBL_WIDTH-1:0] obj_root,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 busy,
    output logic [LBL_WIDTH-1:0] out_count,
    output logic                 scan_done,
    output logic                 overrun,
    object_readout_ctrl_if.master out_bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StPresent, StDone} state_e;

    localparam logic [LOC_SIZE-1:0]  MinArea = LOC_SIZE'(MIN_AREA);
    localparam logic [2:0]           RdLat   = 3'(RD_LAT);
    localparam logic [LBL_WIDTH-1:0] LblOne  = LBL_WIDTH'(1);

    state_e               state;
    logic [LBL_WIDTH-1:0] last;
    logic [2:0]           wait_cnt;
    logic                 keep;
    logic                 at_last;
    logic                 eval_now;

    // obj_id doubles as the label cursor k, so the root test compares against it.
    assign keep    = (obj_root == obj_id) && (obj_area >= MinArea);
    assign at_last = (obj_id == last);

    // Table data is valid in ISSUE when there is no latency, otherwise on the
    // WAIT cycle whose decrement takes the counter to zero.
    always_comb begin
        eval_now = 1'b0;
        case (state)
            StIssue: eval_now = (RD_LAT == 0);
            StWait:  eval_now = (wait_cnt == 3'd1);
            default: eval_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= StIdle;
            last              <= '0;
            wait_cnt          <= '0;
            obj_id            <= '0;
            busy              <= 1'b0;
            out_count         <= '0;
            scan_done         <= 1'b0;
            overrun           <= 1'b0;
            out_bus.out_valid <= 1'b0;
            out_bus.out_id    <= '0;
            out_bus.out_area  <= '0;
            out_bus.out_x     <= '0;
            out_bus.out_y     <= '0;
        end else begin
            scan_done <= 1'b0;
            // A second frame_done during a scan is dropped; only flagged.
            overrun   <= frame_done && (state != StIdle);

            case (state)
                StIdle: begin
                    if (frame_done) begin
                        last      <= num_labels - LblOne;
                        out_count <= '0;
                        busy      <= 1'b1;
                        if (num_labels <= LblOne) begin
                            state     <= StDone;
                            scan_done <= 1'b1;
                        end else begin
                            obj_id <= LblOne;
                            state  <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    wait_cnt <= RdLat;
                    if (RD_LAT != 0) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt - 3'd1;
                end
                StPresent: begin
                    if (out_bus.out_ready) begin
                        out_bus.out_valid <= 1'b0;
                        if (out_count != '1) begin
                            out_count <= out_count + LblOne;
                        end
                        if (at_last) begin
                            state     <= StDone;
                            scan_done <= 1'b1;
                        end else begin
                            obj_id <= obj_id + LblOne;
                            state  <= StIssue;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            // Evaluation overrides the per-state next state above.
            if (eval_now) begin
                if (keep) begin
                    out_bus.out_valid <= 1'b1;
                    out_bus.out_id    <= obj_id;
                    out_bus.out_area  <= obj_area;
                    out_bus.out_x     <= obj_x;
                    out_bus.out_y     <= obj_y;
                    state             <= StPresent;
                end else if (at_last) begin
                    state     <= StDone;
                    scan_done <= 1'b1;
                end else begin
                    obj_id <= obj_id + LblOne;
                    state  <= StIssue;
                end
            end
        end
    end

endmodule

// File: doc/object_readout_ctrl.md
# object_readout_ctrl

Post-frame object readout scheduler for the connected-components labeller. On a frame-done pulse it latches the label count, then walks `obj_id` over labels 1..num_labels-1. For each label it waits out the table read latency and keeps only root labels whose area meets a threshold. Kept objects are presented on a valid/ready stream to the downstream feature/overlay logic, and the block holds off the next frame's labelling while the scan runs.

## Interface
Parameters:
- `LBL_WIDTH`, 8, label/object-id width.
- `LOC_SIZE`, 16, width of area and moment sums.
- `RD_LAT`, 1, cycles from `obj_id` change to valid `obj_*`/`obj_root` data; legal range 0..7.
- `MIN_AREA`, 16, minimum area for an object to be emitted.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_done`  in  1  one-cycle pulse at end of frame labelling.
- `num_labels`  in  LBL_WIDTH  next-free-label count from the labeller; valid when `frame_done`=1.
- `obj_id`  out  LBL_WIDTH  object id driven to the labeller's readout port.
- `obj_root`  in  LBL_WIDTH  merge-resolved id of `obj_id`.
- `obj_area`, `obj_x`, `obj_y`  in  LOC_SIZE  m00, m10, m01 of the resolved object.
- `busy`  out  1  scan in progress; labeller `en` is gated with ~busy.
- `out_valid`  out  1  emitted object available.
- `out_ready`  in  1  downstream accept.
- `out_id`  out  LBL_WIDTH  emitted object id.
- `out_area`, `out_x`, `out_y`  out  LOC_SIZE  emitted sums, captured unmodified.
- `out_count`  out  LBL_WIDTH  objects emitted this scan.
- `scan_done`  out  1  one-cycle pulse at end of scan.
- `overrun`  out  1  one-cycle pulse when `frame_done` arrives while busy.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE, `frame_done`=1:
  - latch `last` = num_labels-1;
  - clear `out_count`;
  - if num_labels ≤ 1, go to DONE;
  - else set k=1 and go to ISSUE.
- ISSUE: drive `obj_id`=k. Load the wait counter with RD_LAT. If RD_LAT=0, evaluate this cycle; else go to WAIT.
- WAIT: decrement the counter. Evaluate in the cycle the counter reaches 0.
- Evaluate:
  - keep = (obj_root == k) && (obj_area ≥ MIN_AREA), unsigned compare.
  - Keep: capture `out_id`=k and the three sums, then go to PRESENT.
  - Reject: if k==last go to DONE, else k+1 and go to ISSUE.
- PRESENT: `out_valid`=1. Captured fields stay stable until accepted.
  - On out_valid&out_ready: `out_count`+1, then k==last → DONE, else k+1 → ISSUE.
- DONE: `scan_done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE. It is asserted the cycle after an accepted `frame_done`, deasserted the cycle after DONE.
- `frame_done` while busy: ignored. `overrun` pulses in that cycle; the scan continues unaffected.
- k is LBL_WIDTH bits wide and never exceeds `last`, so it does not wrap. The `out_count` increment saturates at 2^LBL_WIDTH-1.
- `obj_id` holds its last value in IDLE and DONE.
- Reset, asynchronous, takes effect at any point including mid-scan:
  - state=IDLE;
  - `obj_id`, `out_id`, `out_area`, `out_x`, `out_y`, `out_count` = 0;
  - `busy`, `out_valid`, `scan_done`, `overrun` = 0;
  - no pending object survives reset.

## Timing
- `frame_done` at cycle t → `busy`=1 and `obj_id`=1 at t+1.
- Rejected label: RD_LAT+1 cycles.
- Kept label with `out_ready` held high: RD_LAT+2 cycles; `out_valid` is high for exactly one cycle.
- `out_valid` rises the cycle after evaluation.
- After the final label, `scan_done` follows one cycle later; `busy` falls the cycle after that.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-PRESENT, with `out_valid`=1 and `out_ready`=0:
  - required: `out_valid`, `busy` and `out_count` go to 0 asynchronously, before the next clock edge.
  - required: the next `frame_done` starts a fresh scan from `obj_id`=1.
- num_labels=1 → DONE one cycle after `frame_done`; `scan_done` pulses, `out_valid` never rises, `out_count`=0.
- num_labels=4, RD_LAT=1, roots {1,1,3}, areas {20,20,5}, MIN_AREA=16, `out_ready`=1:
  - exactly one object is emitted: id 1, area 20;
  - label 2 is rejected as a non-root, label 3 as undersized;
  - `out_count`=1; `scan_done` pulses 8 cycles after `frame_done`.
- Back-pressure: `out_ready` held low for 5 cycles on a kept object → `out_valid` and all out fields are stable for 5 cycles; the transfer completes on the first high cycle; `obj_id` does not advance meanwhile.
- `frame_done` pulsed at scan midpoint → `overrun` pulses once; the scan result and `out_count` are identical to the run without the pulse.
- RD_LAT=0 and RD_LAT=3 sweep, 10 kept labels with area=MIN_AREA → all 10 are emitted; rejected labels cost exactly RD_LAT+1 cycles each.
